float_subtractor: RTL and testbench



---
 rtl/float_subtractor_if.sv | 15 +
 rtl/float_subtractor.sv | 174 +++++++++++++++++
 tb/tb_float_subtractor.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/float_subtractor_if.sv
// Start/done handshake bundle for float_subtractor: operands in, difference and flags out.
// The master drives the launch request; the slave (the subtractor) returns status and result.
interface float_subtractor_if;
  logic        start;
  logic [15:0] num1;
  logic [15:0] num2;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        overflow;
  logic        zero;

  modport master (output start, num1, num2, input busy, done, result, overflow, zero);
  modport slave  (input start, num1, num2, output busy, done, result, overflow, zero);
endinterface

// File: rtl/float_subtractor.sv
// Multi-cycle 1/5/10 float subtractor (num1 - num2) that aligns and normalizes one bit per clock.
// Only IDLE accepts a launch; result and flags are registered on the NORM->DONE edge.
module float_subtractor (
  input  logic                clk,
  input  logic                rst_n,
  float_subtractor_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_e;

  state_e      state_q,    state_d;
  logic        sign_a_q,   sign_a_d;
  logic [4:0]  exp_a_q,    exp_a_d;
  logic [10:0] mant_a_q,   mant_a_d;
  logic        sign_b_q,   sign_b_d;
  logic [4:0]  exp_b_q,    exp_b_d;
  logic [10:0] mant_b_q,   mant_b_d;
  logic [11:0] sum_q,      sum_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;
  logic [15:0] result_q,   result_d;
  logic        overflow_q, overflow_d;
  logic        zero_q,     zero_d;

  // exp==0 with fra==0 is the only zero encoding; everything else carries the hidden 1.
  function automatic logic [10:0] mant_of(input logic [15:0] x);
    if (x[14:10] == 5'd0 && x[9:0] == 10'd0) begin
      return 11'd0;
    end else begin
      return {1'b1, x[9:0]};
    end
  endfunction

  // Next-state, datapath and output computation for all registers.
  always_comb begin
    state_d    = state_q;
    sign_a_d   = sign_a_q;
    exp_a_d    = exp_a_q;
    mant_a_d   = mant_a_q;
    sign_b_d   = sign_b_q;
    exp_b_d    = exp_b_q;
    mant_b_d   = mant_b_q;
    sum_d      = sum_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Subtraction is addition of the negated subtrahend; num1 wins exponent ties.
          if (bus.num2[14:10] > bus.num1[14:10]) begin
            sign_a_d = ~bus.num2[15];
            exp_a_d  = bus.num2[14:10];
            mant_a_d = mant_of(bus.num2);
            sign_b_d = bus.num1[15];
            exp_b_d  = bus.num1[14:10];
            mant_b_d = mant_of(bus.num1);
          end else begin
            sign_a_d = bus.num1[15];
            exp_a_d  = bus.num1[14:10];
            mant_a_d = mant_of(bus.num1);
            sign_b_d = ~bus.num2[15];
            exp_b_d  = bus.num2[14:10];
            mant_b_d = mant_of(bus.num2);
          end
          state_d = S_ALIGN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ALIGN: begin
        if (exp_b_q == exp_a_q || mant_b_q == 11'd0) begin
          state_d = S_ADD;
        end else begin
          mant_b_d = mant_b_q >> 1;
          exp_b_d  = exp_b_q + 5'd1;
        end
      end
      S_ADD: begin
        if (sign_a_q == sign_b_q) begin
          sum_d = {1'b0, mant_a_q} + {1'b0, mant_b_q};
        end else if (mant_a_q >= mant_b_q) begin
          sum_d = {1'b0, mant_a_q} - {1'b0, mant_b_q};
        end else begin
          sum_d    = {1'b0, mant_b_q} - {1'b0, mant_a_q};
          sign_a_d = sign_b_q;
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        if (sum_q == 12'd0) begin
          result_d   = 16'h0000;
          overflow_d = 1'b0;
          zero_d     = 1'b1;
          state_d    = S_DONE;
        end else if (sum_q[11]) begin
          if (exp_a_q == 5'd31) begin
            result_d   = {sign_a_q, 5'h1F, 10'h3FF};
            overflow_d = 1'b1;
          end else begin
            result_d   = {sign_a_q, exp_a_q + 5'd1, sum_q[10:1]};
            overflow_d = 1'b0;
          end
          zero_d  = 1'b0;
          state_d = S_DONE;
        end else if (sum_q[10]) begin
          result_d   = {sign_a_q, exp_a_q, sum_q[9:0]};
          overflow_d = 1'b0;
          zero_d     = 1'b0;
          state_d    = S_DONE;
        end else if (exp_a_q == 5'd0) begin
          // Underflow: no denormals, so flush to positive zero.
          result_d   = 16'h0000;
          overflow_d = 1'b0;
          zero_d     = 1'b1;
          state_d    = S_DONE;
        end else begin
          sum_d   = sum_q << 1;
          exp_a_d = exp_a_q - 5'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_ALIGN) || (state_d == S_ADD) || (state_d == S_NORM);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sign_a_q   <= 1'b0;
      exp_a_q    <= 5'd0;
      mant_a_q   <= 11'd0;
      sign_b_q   <= 1'b0;
      exp_b_q    <= 5'd0;
      mant_b_q   <= 11'd0;
      sum_q      <= 12'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 16'h0000;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_a_q   <= sign_a_d;
      exp_a_q    <= exp_a_d;
      mant_a_q   <= mant_a_d;
      sign_b_q   <= sign_b_d;
      exp_b_q    <= exp_b_d;
      mant_b_q   <= mant_b_d;
      sum_q      <= sum_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_float_subtractor.sv
// Randomized self-checking bench for float_subtractor against an arithmetic reference model.
// An operation launched by driving start just after edge k must raise done just after edge k+4+m+L.
module tb_float_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  float_subtractor_if bus ();
  float_subtractor dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: value-level subtraction with truncating alignment and normalization.
  function automatic void model(input logic [15:0] n1, input logic [15:0] n2,
                                output logic [15:0] r, output bit ov, output bit z,
                                output int lat);
    int e1, e2, m1, m2, s1, s2, ea, eb, ma, mb, sa, sb, d, m, sum, sg, p, s, l;
    e1 = int'(n1[14:10]);
    e2 = int'(n2[14:10]);
    m1 = (e1 == 0 && n1[9:0] == 10'd0) ? 0 : 1024 + int'(n1[9:0]);
    m2 = (e2 == 0 && n2[9:0] == 10'd0) ? 0 : 1024 + int'(n2[9:0]);
    s1 = int'(n1[15]);
    s2 = 1 - int'(n2[15]);
    if (e2 > e1) begin
      ea = e2; ma = m2; sa = s2; eb = e1; mb = m1; sb = s1;
    end else begin
      ea = e1; ma = m1; sa = s1; eb = e2; mb = m2; sb = s2;
    end
    d = ea - eb;
    if (mb == 0) m = 0;
    else m = (d < 11) ? d : 11;
    mb = (d >= 11) ? 0 : (mb >> d);
    if (sa == sb) begin
      sum = ma + mb; sg = sa;
    end else if (ma >= mb) begin
      sum = ma - mb; sg = sa;
    end else begin
      sum = mb - ma; sg = sb;
    end
    l = 0; ov = 0; z = 0; r = 16'h0000;
    if (sum == 0) begin
      z = 1;
    end else if (sum >= 2048) begin
      if (ea == 31) begin
        ov = 1; r = {sg[0], 5'h1F, 10'h3FF};
      end else begin
        r = 16'((sg << 15) | ((ea + 1) << 10) | ((sum >> 1) & 1023));
      end
    end else begin
      p = 10;
      while (sum < (1 << p)) p--;
      s = 10 - p;
      if (ea >= s) begin
        l = s;
        r = 16'((sg << 15) | ((ea - s) << 10) | ((sum << s) & 1023));
      end else begin
        l = ea;
        z = 1;
      end
    end
    lat = 4 + m + l;
  endfunction

  // Launches one operation; inject>1 pulses a spurious start at that cycle offset.
  task automatic run_op(input logic [15:0] n1, input logic [15:0] n2, input int inject);
    logic [15:0] er;
    bit eo, ez, seen;
    int el, cnt;
    model(n1, n2, er, eo, ez, el);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num1 = n1; bus.num2 = n2;
    cnt = 0; seen = 0;
    while (!seen && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 1) begin
        bus.start = 1'b0; bus.num1 = 16'($urandom); bus.num2 = 16'($urandom);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
      end
      if (inject > 1 && cnt == inject) bus.start = 1'b1;
      if (inject > 1 && cnt == inject + 1) bus.start = 1'b0;
      if (bus.done) seen = 1;
    end
    bus.start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cnt), 32'(el));
    check("result", 32'(bus.result), 32'(er));
    check("overflow", 32'(bus.overflow), 32'(eo));
    check("zero", 32'(bus.zero), 32'(ez));
    check("busy_at_done", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("done_width", 32'(bus.done), 32'd0);
    if (inject > 1) begin
      repeat (30) begin
        @(posedge clk); #1;
        check("no_second_done", 32'(bus.done), 32'd0);
      end
    end
  endtask

  logic [15:0] a, b;
  int pulses;

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.num1 = 16'h0000; bus.num2 = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(16'h5200, 16'h5000, 0);
    run_op(16'h6A74, 16'h6A74, 0);
    run_op(16'h3C00, 16'hBC00, 0);
    run_op(16'h7FFF, 16'hFFFF, 0);
    run_op(16'h3C00, 16'h4000, 2);
    run_op(16'h7C00, 16'h0400, 0);
    run_op(16'h0400, 16'h0600, 0);
    run_op(16'h0000, 16'h0000, 0);

    for (int i = 0; i < 150; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case (i % 5)
        1: b = {b[15], a[14:10], b[9:0]};
        2: b = {a[15], a[14:10] ^ {3'b000, b[11:10]}, b[9:0]};
        3: b = a;
        4: a = 16'h0000;
        default: b = b;
      endcase
      run_op(a, b, 0);
    end

    // Reset in the middle of a long alignment.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num1 = 16'h7C00; bus.num2 = 16'h0400;
    repeat (5) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_overflow", 32'(bus.overflow), 32'd0);
    check("midrst_zero", 32'(bus.zero), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    run_op(16'h4000, 16'h3C00, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
